banked_data_memory: RTL and testbench
=====================================

// Module: banked_data_memory
// PURPOSE
//  Byte-lane banked data memory with valid/ready request and response handshakes, used as the CPU core's load/store memory.
//  Generalises the fixed 4-lane store/load memory to NUM_LANES byte lanes and supports byte..doubleword sizes.
//  Accesses that cross a row boundary are handled by a two-row FSM sequence with little-endian byte order.
//  Loads are sign- or zero-extended; illegal sizes return an error response and leave memory untouched.
// PARAMETERS
//  NUM_LANES   4   byte lanes per row, must be 4 or 8; data width DW = 8*NUM_LANES
//  ADDR_WIDTH  10  byte-address width; memory holds 2^ADDR_WIDTH bytes, ROWS = 2^ADDR_WIDTH/NUM_LANES
// PORTS
//  clk             in   1           clock, all state updates on rising edge
//  i_rst           in   1           synchronous reset, active high
//  i_req_valid     in   1           request valid
//  o_req_ready     out  1           request ready; high only in IDLE
//  i_req_we        in   1           1 = store, 0 = load
//  i_req_addr      in   ADDR_WIDTH  byte address
//  i_req_size      in   2           log2(bytes): 00 B, 01 H, 10 W, 11 D
//  i_req_unsigned  in   1           load: 1 = zero-extend, 0 = sign-extend
//  i_req_wdata     in   DW          store data, byte k goes to address addr+k
//  o_rsp_valid     out  1           one-cycle response pulse (load data or store ack)
//  o_rsp_rdata     out  DW          extended load data; 0 for stores and errors
//  o_rsp_err       out  1           illegal size: (1<<size) > NUM_LANES
//  o_rsp_split     out  1           response needed two row accesses
// BEHAVIOUR
//  Reset values: o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_rsp_split=0, FSM in IDLE.
//  Reset does not clear memory contents. Reset has priority over every event, including in-flight writes.
//  Mapping: byte address A -> lane A%NUM_LANES, row A/NUM_LANES. Addresses wrap modulo 2^ADDR_WIDTH, so row ROWS-1+1 = row 0.
//  Accept: on a rising edge with i_req_valid && o_req_ready, all request fields are latched. Fields are ignored otherwise.
//  split = (A%NUM_LANES + (1<<size)) > NUM_LANES.
//  FSM: IDLE -accept-> ACC0 -> (split ? ACC1 : RESP); ACC1 -> RESP; RESP -> IDLE.
//       An erroring request goes IDLE -> RESP directly with no memory access.
//  ACC0: accesses row A/NUM_LANES with lane enables for the in-row bytes.
//  ACC1: accesses the next row (wrapping) for the remaining low lanes.
//  Stores write only the enabled lanes; other bytes are unchanged. Write enables are gated by !i_rst.
//  Lanes have a registered (synchronous) read. Read bytes are rotated by A%NUM_LANES and merged across the two rows.
//  The result is then extended from 8<<size bits to DW bits; there is no extension when 8<<size == DW.
//  RESP: o_rsp_valid=1 for exactly one cycle, with rdata/err/split valid in the same cycle. Outputs return to 0 in IDLE.
//  Latency from the accept edge E: o_rsp_valid high in the cycle after edge E+2 (non-split) or E+3 (split).
//       An error responds after edge E+1.
//  Throughput: next accept is possible in IDLE following RESP, i.e. at most one request per 4 cycles (5 if split).
//  No response backpressure: o_rsp_valid must be sampled when asserted.
//  Reset mid-operation: FSM returns to IDLE at the reset edge and the pending response is dropped.
//       A split store reset during ACC1 keeps its ACC0 bytes and does not write its ACC1 bytes.
// TESTING (NUM_LANES=4, ADDR_WIDTH=10 unless stated)
//  1 Reset: hold i_rst 2 cycles -> o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, err=0, split=0.
//  2 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp 2 cycles after accept, rdata=0xDEADBEEF, split=0.
//    LBU @0x013 returns 0x000000DE.
//  3 SH 0xA5F0 @0x00B -> split=1, 3-cycle latency.
//    LH @0x00B returns 0xFFFFA5F0; LB @0x00B returns 0xFFFFFFF0; LBU @0x00C returns 0x000000A5.
//  4 SW 0x11223344 @0x3FF -> split=1, wraps to row 0. LW @0x3FF returns 0x11223344; LBU @0x000 returns 0x00000033.
//  5 Load/store with size=11 -> rsp after 1 cycle with err=1, rdata=0, memory unchanged on readback.
//    With NUM_LANES=8: SD then LD of 0x0123456789ABCDEF @0x005 round-trips with split=1.
//  6 Start SW 0xCAFEF00D @0x002 and assert i_rst in ACC1 -> no rsp, IDLE next cycle.
//    LHU @0x002 returns 0x0000F00D; LHU @0x004 returns its pre-store value.

Source files
------------

// File: rtl/banked_data_memory.sv
// Byte-lane banked load/store memory with valid/ready handshakes.
// Row-crossing accesses take two row cycles; loads are sign/zero extended.
module banked_data_memory #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [1:0]             i_req_size,
  input  logic                   i_req_unsigned,
  input  logic [8*NUM_LANES-1:0] i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [8*NUM_LANES-1:0] o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_rsp_split
);

  localparam int DW   = 8 * NUM_LANES;
  localparam int LW   = $clog2(NUM_LANES);
  localparam int RW   = ADDR_WIDTH - LW;
  localparam int ROWS = 1 << RW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic          we_q, uns_q, err_q, split_q;
  logic [1:0]    size_q;
  logic [LW-1:0] off_q;
  logic [RW-1:0] row_q;
  logic [DW-1:0] wdata_q;

  logic accept;
  int   req_nb;
  logic req_err, req_split;

  int                     off, nb;
  logic [2*NUM_LANES-1:0] mask;
  logic [RW-1:0]          acc_row;
  logic [NUM_LANES-1:0]   wr_en;
  logic [7:0]             wlane  [NUM_LANES];
  logic [7:0]             lane_q [NUM_LANES];
  logic [7:0]             hold   [NUM_LANES];
  logic [7:0]             merged [NUM_LANES];
  logic [DW-1:0]          raw, ext;
  logic                   sign;

  assign o_req_ready = (state == S_IDLE) && !o_rsp_valid;
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    req_nb    = 1 << i_req_size;
    req_err   = req_nb > NUM_LANES;
    req_split = (int'(i_req_addr[LW-1:0]) + req_nb) > NUM_LANES;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = req_err ? S_RESP : S_ACC0;
      S_ACC0: state_nxt = split_q ? S_ACC1 : S_RESP;
      S_ACC1: state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_rsp_split <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_rsp_valid <= state == S_RESP;
      o_rsp_err   <= (state == S_RESP) && err_q;
      o_rsp_split <= (state == S_RESP) && split_q;
      if (state == S_RESP && !we_q && !err_q) o_rsp_rdata <= ext;
      else o_rsp_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst && state == S_IDLE && accept) begin
      we_q    <= i_req_we;
      uns_q   <= i_req_unsigned;
      size_q  <= i_req_size;
      err_q   <= req_err;
      split_q <= req_split && !req_err;
      off_q   <= i_req_addr[LW-1:0];
      row_q   <= i_req_addr[ADDR_WIDTH-1:LW];
      wdata_q <= i_req_wdata;
    end
  end

  // Low half of mask = first row lanes, high half = wrapped lanes of next row
  always_comb begin
    off     = int'(off_q);
    nb      = err_q ? 1 : (1 << size_q);
    acc_row = (state == S_ACC1) ? row_q + RW'(1) : row_q;
    for (int k = 0; k < 2 * NUM_LANES; k++)
      mask[k] = (k >= off) && (k < off + nb);
    for (int l = 0; l < NUM_LANES; l++) begin
      wlane[l] = wdata_q[8*((l - off + NUM_LANES) % NUM_LANES) +: 8];
      wr_en[l] = !i_rst && we_q &&
                 ((state == S_ACC0 && mask[l]) ||
                  (state == S_ACC1 && mask[NUM_LANES+l]));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] mem [ROWS];
    always_ff @(posedge clk) begin
      if (wr_en[g]) mem[acc_row] <= wlane[g];
      lane_q[g] <= mem[acc_row];
      if (state == S_ACC1) hold[g] <= lane_q[g];
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++)
      merged[l] = (split_q && mask[l]) ? hold[l] : lane_q[l];
    for (int k = 0; k < NUM_LANES; k++)
      raw[8*k +: 8] = merged[(off + k) % NUM_LANES];
    sign = raw[8*nb-1] && !uns_q;
    for (int k = 0; k < NUM_LANES; k++)
      ext[8*k +: 8] = (k < nb) ? raw[8*k +: 8] : {8{sign}};
  end

endmodule

// File: tb/tb_banked_data_memory.sv
// Self-checking bench for banked_data_memory.
// Directed table, random ops vs byte-array model, reset and 8-lane cases.
module tb_banked_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v4, rdy4, we4, uns4, rv4, err4, spl4;
  logic [9:0]  a4;
  logic [1:0]  sz4;
  logic [31:0] wd4, rd4;
  logic        v8, rdy8, we8, uns8, rv8, err8, spl8;
  logic [9:0]  a8;
  logic [1:0]  sz8;
  logic [63:0] wd8, rd8;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [1024];

  banked_data_memory #(.NUM_LANES(4), .ADDR_WIDTH(10)) dut4 (
    .clk(clk), .i_rst(rst), .i_req_valid(v4), .o_req_ready(rdy4),
    .i_req_we(we4), .i_req_addr(a4), .i_req_size(sz4),
    .i_req_unsigned(uns4), .i_req_wdata(wd4), .o_rsp_valid(rv4),
    .o_rsp_rdata(rd4), .o_rsp_err(err4), .o_rsp_split(spl4)
  );

  banked_data_memory #(.NUM_LANES(8), .ADDR_WIDTH(10)) dut8 (
    .clk(clk), .i_rst(rst), .i_req_valid(v8), .o_req_ready(rdy8),
    .i_req_we(we8), .i_req_addr(a8), .i_req_size(sz8),
    .i_req_unsigned(uns8), .i_req_wdata(wd8), .o_rsp_valid(rv8),
    .o_rsp_rdata(rd8), .o_rsp_err(err8), .o_rsp_split(spl8)
  );

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic        use_model;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_spl;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [9:0] addr, logic [1:0] size,
                              logic uns, logic [31:0] wd, logic use_model,
                              logic [31:0] exp_rd, logic exp_err,
                              logic exp_spl, int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wd = wd;
    v.use_model = use_model; v.exp_rd = exp_rd; v.exp_err = exp_err;
    v.exp_spl = exp_spl; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mload(logic [9:0] addr, logic [1:0] size,
                                        logic uns);
    logic [31:0] v;
    int n;
    n = 1 << size;
    v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(addr) + k) % 1024];
    if (!uns && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic mstore(logic [9:0] addr, logic [1:0] size, logic [31:0] wd);
    for (int k = 0; k < (1 << size); k++)
      ref_mem[(int'(addr) + k) % 1024] = wd[8*k +: 8];
  endtask

  task automatic do_req4(input logic we, input logic [9:0] addr,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic err, output logic spl, output int lat);
    int w;
    logic got;
    rd = '0; err = 1'b0; spl = 1'b0; lat = -1; got = 1'b0;
    @(negedge clk);
    w = 0;
    while (!rdy4 && w < 20) begin @(negedge clk); w++; end
    if (!rdy4) chk("ready4_timeout", 0, 1);
    v4 = 1'b1; we4 = we; a4 = addr; sz4 = size; uns4 = uns; wd4 = wd;
    @(posedge clk); #1;
    v4 = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk); #1;
      if (rv4) begin
        got = 1'b1; lat = c; rd = rd4; err = err4; spl = spl4;
      end
    end
    if (!got) chk("rsp4_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
      chk("rsp4_pulse_len", 64'(rv4), 0);
    end
  endtask

  task automatic do_req8(input logic we, input logic [9:0] addr,
                         input logic [1:0] size, input logic uns,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic err, output logic spl, output int lat);
    int w;
    logic got;
    rd = '0; err = 1'b0; spl = 1'b0; lat = -1; got = 1'b0;
    @(negedge clk);
    w = 0;
    while (!rdy8 && w < 20) begin @(negedge clk); w++; end
    if (!rdy8) chk("ready8_timeout", 0, 1);
    v8 = 1'b1; we8 = we; a8 = addr; sz8 = size; uns8 = uns; wd8 = wd;
    @(posedge clk); #1;
    v8 = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk); #1;
      if (rv8) begin
        got = 1'b1; lat = c; rd = rd8; err = err8; spl = spl8;
      end
    end
    if (!got) chk("rsp8_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] rd, exp_rd, wd;
    logic [63:0] rdd;
    logic        err, spl, we, uns, exp_err, exp_spl;
    logic [9:0]  addr;
    logic [1:0]  size;
    int          lat, exp_lat, n, pulses;

    rst = 1'b1;
    v4 = 0; we4 = 0; a4 = 0; sz4 = 0; uns4 = 0; wd4 = 0;
    v8 = 0; we8 = 0; a8 = 0; sz8 = 0; uns8 = 0; wd8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(rdy4), 1);
    chk("rst_valid", 64'(rv4), 0);
    chk("rst_rdata", 64'(rd4), 0);
    chk("rst_err", 64'(err4), 0);
    chk("rst_split", 64'(spl4), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 1024; a += 4) begin
      wd = $urandom;
      do_req4(1'b1, 10'(a), 2'd2, 1'b0, wd, rd, err, spl, lat);
      mstore(10'(a), 2'd2, wd);
    end

    tbl.push_back(mk(1, 10'h010, 2, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 2));
    tbl.push_back(mk(0, 10'h010, 2, 0, 32'h0, 0, 32'hDEADBEEF, 0, 0, 2));
    tbl.push_back(mk(0, 10'h013, 0, 1, 32'h0, 0, 32'h000000DE, 0, 0, 2));
    tbl.push_back(mk(1, 10'h00B, 1, 0, 32'hA5F0, 0, 32'h0, 0, 1, 3));
    tbl.push_back(mk(0, 10'h00B, 1, 0, 32'h0, 0, 32'hFFFFA5F0, 0, 1, 3));
    tbl.push_back(mk(0, 10'h00B, 1, 1, 32'h0, 0, 32'h0000A5F0, 0, 1, 3));
    tbl.push_back(mk(0, 10'h00B, 0, 0, 32'h0, 0, 32'hFFFFFFF0, 0, 0, 2));
    tbl.push_back(mk(0, 10'h00C, 0, 1, 32'h0, 0, 32'h000000A5, 0, 0, 2));
    tbl.push_back(mk(1, 10'h3FF, 2, 0, 32'h11223344, 0, 32'h0, 0, 1, 3));
    tbl.push_back(mk(0, 10'h3FF, 2, 0, 32'h0, 0, 32'h11223344, 0, 1, 3));
    tbl.push_back(mk(0, 10'h000, 0, 1, 32'h0, 0, 32'h00000033, 0, 0, 2));
    tbl.push_back(mk(1, 10'h020, 3, 0, 32'h55555555, 0, 32'h0, 1, 0, 1));
    tbl.push_back(mk(0, 10'h020, 3, 0, 32'h0, 0, 32'h0, 1, 0, 1));
    tbl.push_back(mk(0, 10'h020, 2, 0, 32'h0, 1, 32'h0, 0, 0, 2));

    foreach (tbl[i]) begin
      exp_rd = tbl[i].use_model ?
               mload(tbl[i].addr, tbl[i].size, tbl[i].uns) : tbl[i].exp_rd;
      do_req4(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wd,
              rd, err, spl, lat);
      if (tbl[i].we && !tbl[i].exp_err)
        mstore(tbl[i].addr, tbl[i].size, tbl[i].wd);
      chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(exp_rd));
      chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_split", i), 64'(spl), 64'(tbl[i].exp_spl));
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
    end

    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 10'($urandom);
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      n    = 1 << size;
      exp_err = n > 4;
      exp_spl = !exp_err && (int'(addr) % 4 + n > 4);
      exp_lat = exp_err ? 1 : (exp_spl ? 3 : 2);
      exp_rd  = (we || exp_err) ? 32'h0 : mload(addr, size, uns);
      do_req4(we, addr, size, uns, wd, rd, err, spl, lat);
      if (we && !exp_err) mstore(addr, size, wd);
      chk($sformatf("rnd%0d_rdata", i), 64'(rd), 64'(exp_rd));
      chk($sformatf("rnd%0d_err", i), 64'(err), 64'(exp_err));
      chk($sformatf("rnd%0d_split", i), 64'(spl), 64'(exp_spl));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat));
    end

    @(negedge clk);
    n = 0;
    while (!rdy4 && n < 20) begin @(negedge clk); n++; end
    v4 = 1'b1; we4 = 1'b1; a4 = 10'h002; sz4 = 2'd2; uns4 = 1'b0;
    wd4 = 32'hCAFEF00D;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(rdy4), 1);
    chk("midrst_valid", 64'(rv4), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rv4) pulses++;
    end
    chk("midrst_no_rsp", 64'(pulses), 0);
    ref_mem[2] = 8'h0D;
    ref_mem[3] = 8'hF0;
    exp_rd = mload(10'h004, 2'd1, 1'b1);
    do_req4(1'b0, 10'h002, 2'd1, 1'b1, 32'h0, rd, err, spl, lat);
    chk("midrst_lhu2", 64'(rd), 64'h0000F00D);
    do_req4(1'b0, 10'h004, 2'd1, 1'b1, 32'h0, rd, err, spl, lat);
    chk("midrst_lhu4", 64'(rd), 64'(exp_rd));

    do_req8(1'b1, 10'h005, 2'd3, 1'b0, 64'h0123456789ABCDEF,
            rdd, err, spl, lat);
    chk("n8_sd_split", 64'(spl), 1);
    chk("n8_sd_err", 64'(err), 0);
    chk("n8_sd_lat", 64'(lat), 3);
    do_req8(1'b0, 10'h005, 2'd3, 1'b0, 64'h0, rdd, err, spl, lat);
    chk("n8_ld_rdata", rdd, 64'h0123456789ABCDEF);
    chk("n8_ld_split", 64'(spl), 1);
    do_req8(1'b0, 10'h005, 2'd2, 1'b0, 64'h0, rdd, err, spl, lat);
    chk("n8_lw_rdata", rdd, 64'hFFFFFFFF89ABCDEF);
    do_req8(1'b0, 10'h00C, 2'd0, 1'b1, 64'h0, rdd, err, spl, lat);
    chk("n8_lbu_rdata", rdd, 64'h01);
    chk("n8_lbu_lat", 64'(lat), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
